// File: rtl/i2c_target_if.sv
// Bus bundle between the I2C target and its surroundings: split SDA/SCL pad
// signals plus the byte-wide register port.
interface i2c_target_if;
   logic       scl_i;
   logic       sda_i;
   logic       sda_o;
   logic       sda_t;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;

   modport slave (
      input  scl_i, sda_i, reg_rdata,
      output sda_o, sda_t, reg_addr, reg_wdata, reg_we, reg_re, busy
   );

   modport master (
      output scl_i, sda_i, reg_rdata,
      input  sda_o, sda_t, reg_addr, reg_wdata, reg_we, reg_re, busy
   );
endinterface

// File: rtl/i2c_target.sv
// 7-bit-address I2C target with an 8-bit register pointer; never drives SCL.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | bus free, waiting for START
// ST_ADDR    | shifting in the address byte
// ST_ADDR_ACK| address matched, driving ACK; R/W selects next state
// ST_WR_PTR  | receiving the register pointer
// ST_PTR_ACK | ACKing the pointer byte
// ST_WR_DATA | receiving a write data byte
// ST_DATA_ACK| ACKing a write data byte
// ST_RD_BYTE | shifting a read byte out on SDA
// ST_RD_ACK  | SDA released, sampling the master's ACK/NACK
// ST_IGNORE  | not addressed or read ended; wait for START/STOP
module i2c_target #(
   parameter logic [6:0] DEV_ADDR   = 7'h41,
   parameter int         FILTER_LEN = 3
) (
   input  logic          clk,
   input  logic          rst,
   i2c_target_if.slave   bus
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_PTR,
      ST_PTR_ACK,
      ST_WR_DATA,
      ST_DATA_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   // index 1 = scl, index 0 = sda
   logic [1:0]      pad_in;
   logic [1:0]      sync1, sync2, filt, filt_q;
   logic [1:0][3:0] cnt;

   assign pad_in = {bus.scl_i, bus.sda_i};

   // A new level is accepted only after FILTER_LEN consecutive identical samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         filt   <= 2'b11;
         filt_q <= 2'b11;
         cnt    <= '0;
      end else begin
         sync1  <= pad_in;
         sync2  <= sync1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               cnt[i] <= 4'd0;
            end else if (cnt[i] == 4'(FILTER_LEN - 1)) begin
               filt[i] <= sync2[i];
               cnt[i]  <= 4'd0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   logic scl_f, scl_q, sda_f, sda_q;
   logic start_evt, stop_evt, scl_rise, scl_fall;

   assign scl_f     = filt[1];
   assign scl_q     = filt_q[1];
   assign sda_f     = filt[0];
   assign sda_q     = filt_q[0];
   assign start_evt = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_evt  = scl_f & scl_q & ~sda_q & sda_f;
   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;

   state_t     state;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic [7:0] ptr;
   logic       rw;
   logic       re_d1;
   logic       inc_pend;
   logic [7:0] rx_byte;
   logic       last_bit;

   assign rx_byte   = {shift[6:0], sda_f};
   assign last_bit  = (bit_cnt == 3'd7);
   assign bus.sda_o = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         shift         <= '0;
         bit_cnt       <= '0;
         ptr           <= '0;
         rw            <= 1'b0;
         re_d1         <= 1'b0;
         inc_pend      <= 1'b0;
         bus.sda_t     <= 1'b1;
         bus.reg_addr  <= '0;
         bus.reg_wdata <= '0;
         bus.reg_we    <= 1'b0;
         bus.reg_re    <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.reg_we <= 1'b0;
         bus.reg_re <= 1'b0;
         re_d1      <= bus.reg_re;
         inc_pend   <= 1'b0;
         if (inc_pend) ptr <= ptr + 8'd1;
         // read data is taken two clk after the read strobe
         if (re_d1) shift <= bus.reg_rdata;

         if (stop_evt) begin
            state     <= ST_IDLE;
            bus.busy  <= 1'b0;
            bus.sda_t <= 1'b1;
         end else if (start_evt) begin
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            bus.sda_t <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state    <= ST_ADDR_ACK;
                           bus.busy <= 1'b1;
                           rw       <= rx_byte[0];
                        end else begin
                           state    <= ST_IGNORE;
                           bus.busy <= 1'b0;
                        end
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     bus.sda_t <= 1'b0;
                  end else if (scl_rise) begin
                     bit_cnt <= 3'd0;
                     if (rw) begin
                        state        <= ST_RD_BYTE;
                        bus.reg_addr <= ptr;
                        bus.reg_re   <= 1'b1;
                     end else begin
                        state <= ST_WR_PTR;
                     end
                  end
               end
               ST_PTR_ACK, ST_DATA_ACK: begin
                  if (scl_fall) begin
                     bus.sda_t <= 1'b0;
                  end else if (scl_rise) begin
                     bit_cnt <= 3'd0;
                     state   <= ST_WR_DATA;
                  end
               end
               ST_WR_PTR: begin
                  if (scl_fall) begin
                     bus.sda_t <= 1'b1;
                  end else if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        ptr   <= rx_byte;
                        state <= ST_PTR_ACK;
                     end
                  end
               end
               ST_WR_DATA: begin
                  if (scl_fall) begin
                     bus.sda_t <= 1'b1;
                  end else if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        bus.reg_wdata <= rx_byte;
                        bus.reg_addr  <= ptr;
                        bus.reg_we    <= 1'b1;
                        inc_pend      <= 1'b1;
                        state         <= ST_DATA_ACK;
                     end
                  end
               end
               ST_RD_BYTE: begin
                  if (scl_fall) begin
                     bus.sda_t <= shift[7];
                     shift     <= {shift[6:0], 1'b0};
                  end else if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) state <= ST_RD_ACK;
                  end
               end
               ST_RD_ACK: begin
                  if (scl_fall) begin
                     bus.sda_t <= 1'b1;
                  end else if (scl_rise) begin
                     bit_cnt <= 3'd0;
                     if (!sda_f) begin
                        ptr          <= ptr + 8'd1;
                        bus.reg_addr <= ptr + 8'd1;
                        bus.reg_re   <= 1'b1;
                        state        <= ST_RD_BYTE;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
               ST_IGNORE: bus.sda_t <= 1'b1;
               default:   state     <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master plus a transaction-level model
// of pointer/register behaviour.
module tb_i2c_target;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;

   always #5 clk = ~clk;

   i2c_target_if bus ();

   assign bus.scl_i     = m_scl;
   assign bus.sda_i     = m_sda & (bus.sda_t ? 1'b1 : bus.sda_o);
   assign bus.reg_rdata = bus.reg_addr ^ 8'h5A;

   i2c_target #(.DEV_ADDR(7'h41), .FILTER_LEN(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_vec = 0;
   int         n_err = 0;
   int         both_cnt = 0;
   logic [7:0] mdl_ptr = 8'h00;
   logic [15:0] we_q[$];
   logic [7:0]  re_q[$];
   logic        drove = 1'b0;
   logic        busy_seen = 1'b0;

   always @(negedge clk) begin
      if (bus.reg_we) we_q.push_back({bus.reg_addr, bus.reg_wdata});
      if (bus.reg_re) re_q.push_back(bus.reg_addr);
      if (bus.reg_we && bus.reg_re) both_cnt++;
      if (!bus.sda_t) drove = 1'b1;
      if (bus.busy) busy_seen = 1'b1;
   end

   task automatic qtr();
      repeat (10) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; qtr();
      m_scl = 1'b1; qtr();
      m_sda = 1'b0; qtr();
      m_scl = 1'b0; qtr();
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; qtr();
      m_scl = 1'b1; qtr();
      m_sda = 1'b1; qtr();
      qtr();
   endtask

   task automatic send_bit(input logic b, output logic line);
      m_sda = b; qtr();
      m_scl = 1'b1; qtr();
      line = bus.sda_i; qtr();
      m_scl = 1'b0; qtr();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
      send_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic dummy;
      for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
      send_bit(nack, dummy);
   endtask

   task automatic clear_mon();
      we_q.delete();
      re_q.delete();
      drove = 1'b0;
      busy_seen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_vec++; if (bus.sda_t !== 1'b1) begin n_err++; $display("FAIL reset_sda_t got %b want 1", bus.sda_t); end
      n_vec++; if (bus.sda_o !== 1'b0) begin n_err++; $display("FAIL reset_sda_o got %b want 0", bus.sda_o); end
      n_vec++; if (bus.reg_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", bus.reg_we); end
      n_vec++; if (bus.reg_re !== 1'b0) begin n_err++; $display("FAIL reset_re got %b want 0", bus.reg_re); end
      n_vec++; if (bus.reg_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", bus.reg_addr); end
      n_vec++; if (bus.reg_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata got %h want 00", bus.reg_wdata); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      rst = 1'b0;
      mdl_ptr = 8'h00;
      qtr();
   endtask

   // Write transaction: pointer byte then n data bytes; checks ACKs, busy and strobes.
   task automatic write_txn(input string tag, input logic [7:0] p, input logic [7:0] data [4], input int n);
      logic        ack;
      logic [7:0]  a;
      logic [15:0] exp_q[$];
      clear_mon();
      bus_start();
      send_byte(8'h82, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s addr_ack got %b want 0", tag, ack); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL %s busy_on got %b want 1", tag, bus.busy); end
      send_byte(p, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s ptr_ack got %b want 0", tag, ack); end
      for (int k = 0; k < n; k++) begin
         send_byte(data[k], ack);
         n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s data%0d_ack got %b want 0", tag, k, ack); end
      end
      bus_stop();
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s busy_off got %b want 0", tag, bus.busy); end
      a = p;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({a, data[k]});
         a = a + 8'd1;
      end
      mdl_ptr = a;
      n_vec++;
      if (we_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL %s we_count got %0d want %0d", tag, we_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < we_q.size(); k++) begin
         n_vec++;
         if (we_q[k] !== exp_q[k]) begin
            n_err++; $display("FAIL %s we%0d addr/data got %h want %h", tag, k, we_q[k], exp_q[k]);
         end
      end
      n_vec++; if (re_q.size() != 0) begin n_err++; $display("FAIL %s stray_re got %0d want 0", tag, re_q.size()); end
   endtask

   // Read k bytes, optionally after setting the pointer; model returns addr^5A.
   task automatic read_txn(input string tag, input logic set_ptr, input logic [7:0] p, input int k);
      logic       ack;
      logic [7:0] d, a;
      clear_mon();
      bus_start();
      if (set_ptr) begin
         send_byte(8'h82, ack);
         send_byte(p, ack);
         n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s ptr_ack got %b want 0", tag, ack); end
         bus_start();
         a = p;
      end else begin
         a = mdl_ptr;
      end
      send_byte(8'h83, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s rd_addr_ack got %b want 0", tag, ack); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL %s busy_on got %b want 1", tag, bus.busy); end
      for (int j = 0; j < k; j++) begin
         recv_byte(j == k - 1, d);
         n_vec++;
         if (d !== (8'(a + 8'(j)) ^ 8'h5A)) begin
            n_err++; $display("FAIL %s rd%0d got %h want %h", tag, j, d, 8'(a + 8'(j)) ^ 8'h5A);
         end
      end
      n_vec++; if (bus.sda_t !== 1'b1) begin n_err++; $display("FAIL %s release_after_nack got %b want 1", tag, bus.sda_t); end
      bus_stop();
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s busy_off got %b want 0", tag, bus.busy); end
      n_vec++;
      if (re_q.size() != k) begin n_err++; $display("FAIL %s re_count got %0d want %0d", tag, re_q.size(), k); end
      for (int j = 0; j < k && j < re_q.size(); j++) begin
         n_vec++;
         if (re_q[j] !== 8'(a + 8'(j))) begin
            n_err++; $display("FAIL %s re%0d addr got %h want %h", tag, j, re_q[j], 8'(a + 8'(j)));
         end
      end
      n_vec++; if (we_q.size() != 0) begin n_err++; $display("FAIL %s stray_we got %0d want 0", tag, we_q.size()); end
      mdl_ptr = a + 8'(k - 1);
   endtask

   task automatic test_write();
      write_txn("write", 8'h10, '{8'hA1, 8'hB2, 8'hC3, 8'h00}, 3);
   endtask

   task automatic test_ptr_read();
      read_txn("ptr_read", 1'b1, 8'h20, 2);
   endtask

   task automatic test_mismatch();
      logic ack;
      clear_mon();
      bus_start();
      send_byte(8'h84, ack);
      n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mismatch_addr_ack got %b want 1", ack); end
      send_byte(8'h00, ack);
      n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mismatch_b1_ack got %b want 1", ack); end
      send_byte(8'h55, ack);
      n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL mismatch_b2_ack got %b want 1", ack); end
      bus_stop();
      n_vec++; if (drove !== 1'b0) begin n_err++; $display("FAIL mismatch_sda_driven got %b want 0", drove); end
      n_vec++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL mismatch_busy got %b want 0", busy_seen); end
      n_vec++; if (we_q.size() != 0) begin n_err++; $display("FAIL mismatch_we got %0d want 0", we_q.size()); end
   endtask

   task automatic test_wrap();
      write_txn("wrap", 8'hFF, '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
   endtask

   task automatic test_zero_data();
      write_txn("zero_data", 8'h5C, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);
      read_txn("read_current", 1'b0, 8'h00, 1);
   endtask

   task automatic test_glitch();
      logic ack;
      clear_mon();
      @(negedge clk) m_sda = 1'b0;
      @(negedge clk);
      @(negedge clk) m_sda = 1'b1;
      qtr();
      m_scl = 1'b0; qtr();
      send_byte(8'h82, ack);
      n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL glitch_ack got %b want 1", ack); end
      n_vec++; if (drove !== 1'b0) begin n_err++; $display("FAIL glitch_sda_driven got %b want 0", drove); end
      n_vec++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b want 0", busy_seen); end
      bus_stop();
   endtask

   task automatic test_random();
      logic [7:0] d [4];
      logic [7:0] p;
      int         n;
      for (int it = 0; it < 4; it++) begin
         p = 8'($urandom);
         n = $urandom_range(0, 3);
         for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
         write_txn("rand_write", p, d, n);
         p = 8'($urandom);
         read_txn("rand_read", 1'b1, p, $urandom_range(1, 3));
      end
      read_txn("rand_read_cur", 1'b0, 8'h00, 2);
   endtask

   task automatic test_reset_mid_read();
      logic ack;
      bus_start();
      send_byte(8'h82, ack);
      send_byte(8'h30, ack);
      bus_start();
      send_byte(8'h83, ack);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL midrst_addr_ack got %b want 0", ack); end
      m_sda = 1'b1; qtr();
      m_scl = 1'b1; qtr();
      // first bit of 0x30^0x5A = 0x6A is 0, so the target is pulling SDA low
      n_vec++; if (bus.sda_t !== 1'b0) begin n_err++; $display("FAIL midrst_driving got %b want 0", bus.sda_t); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++; if (bus.sda_t !== 1'b1) begin n_err++; $display("FAIL midrst_release got %b want 1", bus.sda_t); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mdl_ptr = 8'h00;
      qtr();
      read_txn("after_reset", 1'b0, 8'h00, 1);
   endtask

   initial begin
      test_reset();
      test_write();
      test_ptr_read();
      test_mismatch();
      test_wrap();
      test_zero_data();
      test_glitch();
      test_random();
      test_reset_mid_read();
      n_vec++; if (both_cnt != 0) begin n_err++; $display("FAIL we_re_overlap got %0d want 0", both_cnt); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (slave) with a byte-wide register-port back end.
- Lets an external I2C master (host MCU, test jig, or a second FPGA's i2c_master) read and write an 8-bit-addressed register space inside the gateware.
- Uses the same split scl/sda _i/_o/_t pad convention as the existing I2C masters. Top level wires pads as pin = t ? Z : o.
- No clock stretching. The block never drives SCL.

Parameters:
- DEV_ADDR, 7'h41, 7-bit device address this target answers to.
- FILTER_LEN, 3, number of consecutive clk samples a synchronised scl/sda level must hold before it is accepted (range 1..15).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_o  out  1  SDA output value; constant 0.
- sda_t  out  1  SDA tristate: 1 = released (high-Z), 0 = drive sda_o.
- reg_addr  out  8  register pointer presented with reg_we and reg_re.
- reg_wdata  out  8  write data; valid while reg_we = 1.
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read strobe.
- reg_rdata  in  8  read data; sampled exactly 2 clk after reg_re.
- busy  out  1  1 from an accepted address match until STOP or a non-matching repeated START.

Behaviour:
- Reset: sda_t=1, sda_o=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0, state IDLE.
- Reset mid-transfer releases SDA immediately and asynchronously. The bus is recovered at the next START.
- Input conditioning:
  - scl_i and sda_i each pass a 2-FF synchroniser, then a FILTER_LEN stable-count filter.
  - Edge detection works on the filtered signals only.
  - Timing requirement: each SCL phase and each SDA setup/hold ≥ FILTER_LEN+4 clk.
- Bus events, evaluated on filtered signals:
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - START and STOP take priority over bit handling in every state, including IDLE.
- Bit timing:
  - Data and ACK are sampled on the filtered scl rising edge.
  - sda_t is updated on the filtered scl falling edge.
- States and transitions:
  - IDLE: START → ADDR (bit count 0).
  - ADDR: shift 8 bits, MSB first.
    - On the 8th rise: if byte[7:1]==DEV_ADDR, go to ADDR_ACK and set busy=1.
    - Otherwise go to IGNORE with SDA released.
  - ADDR_ACK:
    - Drive sda_t=0 from the falling edge after bit 8 until the falling edge after the ACK clock.
    - R/W=0 → WR_PTR.
    - R/W=1 → RD_BYTE. reg_re pulses on the ACK-clock rising edge with reg_addr = current pointer.
  - WR_PTR: receive 8 bits; load pointer; ACK; → WR_DATA.
  - WR_DATA:
    - Receive 8 bits.
    - On the 8th rise: reg_wdata=byte, reg_addr=pointer, reg_we=1 for one clk.
    - Pointer increments one clk later; wraps 8'hFF→8'h00.
    - ACK, then → WR_DATA.
  - RD_BYTE:
    - reg_rdata is captured into the shift register 2 clk after reg_re.
    - Each bit is driven on scl falling: sda_t = bit (1 → release, 0 → drive low).
    - After bit 8 the falling edge releases SDA → RD_ACK.
  - RD_ACK: sample the master's ACK on scl rise.
    - ACK (0): pointer++ (wrap), reg_re pulses with the new pointer, → RD_BYTE.
    - NACK (1): → IGNORE.
  - IGNORE: SDA released; wait for START (→ ADDR) or STOP (→ IDLE).
- STOP in any state → IDLE, busy=0, SDA released.
- Repeated START in any state → ADDR.
  - Pointer is retained across repeated START, so write-pointer-then-read works.
  - busy is cleared if the new address does not match.
- A write transaction with zero data bytes only sets the pointer. No reg_we is issued.
- reg_we and reg_re are never asserted in the same clk.

Test Plan:
- Write: START, 0x82, 0x10, 0xA1, 0xB2, 0xC3, STOP → three reg_we pulses at addr 0x10/0x11/0x12 with data A1/B2/C3. Target ACKs all 5 bytes; busy 1→0 at STOP.
- Pointer-then-read: START, 0x82, 0x20, Sr, 0x83, read 2 bytes (ACK, NACK), STOP; model returns addr^0x5A. SDA carries 0x7A then 0x7B. reg_re pulses at 0x20 and 0x21 only; SDA is released after the NACK.
- Address mismatch: START, 0x84, 0x00, 0x55, STOP → no ACK (SDA never driven), no reg_we, busy stays 0.
- Pointer wrap: write pointer 0xFF then data 0x11, 0x22 → reg_we at 0xFF and 0x00.
- Glitch rejection: a 2-clk low pulse on sda_i with scl high and FILTER_LEN=3 → no START detected, state remains IDLE.
- Reset mid-read: assert rst while the target drives SDA low during a data bit → sda_t=1 within the same clk. The next START, 0x83 is ACKed and reads from pointer 0x00.
